// File: rtl/vga_pattern_gen.sv
// VGA 640x480 test-pattern stage: bars, checker, gradient, bouncing box; 2-clock latency, RGB/sync aligned.
// No backpressure: consumes one pixel sample every clock.
module vga_pattern_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BOX_SIZE    = 32,
  parameter int AUTO_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       display_en,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic [1:0] pattern_sel,
  input  logic       auto_cycle,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       h_sync_out,
  output logic       v_sync_out,
  output logic       frame_tick,
  output logic [1:0] pattern_cur
);

  localparam int          CW       = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(AUTO_FRAMES - 1);
  localparam logic [9:0]  BAR_W    = 10'(H_ACTIVE / 8);
  localparam logic [9:0]  XMAX     = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  YMAX     = 10'(V_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  V_START  = 10'(V_ACTIVE);
  localparam logic [10:0] BOX      = 11'(BOX_SIZE);

  // S1 sample registers
  logic [9:0] h1, v1;
  logic       de1, hs1, vs1, fs1;

  // Frame-rate state
  logic [9:0]    bx, by;
  logic          dx, dy;
  logic [7:0]    frame_cnt;
  logic [CW-1:0] cyc_cnt;

  logic [3:0]    r_n, g_n, b_n;
  logic [2:0]    bar;
  logic          in_box;
  logic [10:0]   x_upd, y_upd;
  logic [1:0]    pat_n;
  logic [CW-1:0] cyc_n;

  // Returns {new_dir, new_pos}; dir 1 means moving towards pmax.
  function automatic logic [10:0] bounce(input logic [9:0] p, input logic d,
                                         input logic [9:0] pmax);
    logic [10:0] r;
    if (d && p == pmax)       r = {1'b0, p - 10'd1};
    else if (!d && p == 10'd0) r = {1'b1, 10'd1};
    else if (d)               r = {1'b1, p + 10'd1};
    else                      r = {1'b0, p - 10'd1};
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h1  <= '0;
      v1  <= '0;
      de1 <= 1'b0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      fs1 <= 1'b0;
    end else begin
      h1  <= h_count;
      v1  <= v_count;
      de1 <= display_en;
      hs1 <= h_sync_in;
      vs1 <= v_sync_in;
      fs1 <= (h_count == 10'd0) && (v_count == V_START);
    end
  end

  always_comb begin
    r_n    = 4'h0;
    g_n    = 4'h0;
    b_n    = 4'h0;
    bar    = 3'(h1 / BAR_W);
    in_box = ({1'b0, h1} >= {1'b0, bx}) && ({1'b0, h1} < ({1'b0, bx} + BOX)) &&
             ({1'b0, v1} >= {1'b0, by}) && ({1'b0, v1} < ({1'b0, by} + BOX));
    if (de1) begin
      case (pattern_cur)
        2'd0: begin
          // Bar order W,Y,C,G,M,R,B,K maps to inverted index bits.
          r_n = {4{~bar[1]}};
          g_n = {4{~bar[2]}};
          b_n = {4{~bar[0]}};
        end
        2'd1: begin
          if (h1[5] ^ v1[5]) begin
            r_n = 4'hF;
            g_n = 4'hF;
            b_n = 4'hF;
          end
        end
        2'd2: begin
          r_n = h1[7:4];
          g_n = v1[7:4];
          b_n = frame_cnt[3:0];
        end
        default: begin
          if (in_box) begin
            r_n = 4'hF;
            g_n = 4'hF;
            b_n = 4'hF;
          end else begin
            b_n = 4'h8;
          end
        end
      endcase
    end
  end

  always_comb begin
    x_upd = bounce(bx, dx, XMAX);
    y_upd = bounce(by, dy, YMAX);
    pat_n = pattern_cur;
    cyc_n = cyc_cnt;
    if (!auto_cycle) begin
      pat_n = pattern_sel;
      cyc_n = '0;
    end else if (cyc_cnt == CYC_LAST) begin
      pat_n = pattern_cur + 2'd1;
      cyc_n = '0;
    end else begin
      cyc_n = cyc_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      red         <= 4'h0;
      green       <= 4'h0;
      blue        <= 4'h0;
      h_sync_out  <= 1'b1;
      v_sync_out  <= 1'b1;
      frame_tick  <= 1'b0;
      pattern_cur <= 2'd0;
      bx          <= '0;
      by          <= '0;
      dx          <= 1'b1;
      dy          <= 1'b1;
      frame_cnt   <= '0;
      cyc_cnt     <= '0;
    end else begin
      red        <= r_n;
      green      <= g_n;
      blue       <= b_n;
      h_sync_out <= hs1;
      v_sync_out <= vs1;
      frame_tick <= fs1;
      // Frame-rate state only moves on the frame start so the image never tears.
      if (fs1) begin
        frame_cnt   <= frame_cnt + 8'd1;
        {dx, bx}    <= x_upd;
        {dy, by}    <= y_upd;
        pattern_cur <= pat_n;
        cyc_cnt     <= cyc_n;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: inputs change on negedge, outputs read on negedge.
module tb_vga_pattern_gen;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] h_count, v_count;
  logic       display_en, h_sync_in, v_sync_in;
  logic [1:0] pattern_sel;
  logic       auto_cycle;
  logic [3:0] red, green, blue;
  logic       h_sync_out, v_sync_out, frame_tick;
  logic [1:0] pattern_cur;

  int checks   = 0;
  int failures = 0;
  int frames   = 0;

  always #5 clk = ~clk;

  vga_pattern_gen #(.H_ACTIVE(640), .V_ACTIVE(480), .BOX_SIZE(32), .AUTO_FRAMES(3)) dut (
    .clk(clk), .reset(rst_n), .h_count(h_count), .v_count(v_count),
    .display_en(display_en), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .pattern_sel(pattern_sel), .auto_cycle(auto_cycle),
    .red(red), .green(green), .blue(blue),
    .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
    .frame_tick(frame_tick), .pattern_cur(pattern_cur)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_px(input int h, input int v);
    h_count    = 10'(h);
    v_count    = 10'(v);
    display_en = (h < 640) && (v < 480);
  endtask

  task automatic px(input int h, input int v, output logic [11:0] rgb);
    @(negedge clk); set_px(h, v);
    @(negedge clk); set_px(700, 10);
    @(negedge clk); rgb = {red, green, blue};
  endtask

  task automatic tick();
    @(negedge clk); set_px(0, 480);
    @(negedge clk); set_px(700, 10);
    @(negedge clk);
    frames++;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    frames = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0;
    pattern_sel = 2'd2; auto_cycle = 1'b0;
    set_px(10, 10);
    repeat (3) @(negedge clk);
    checks++; if ({red, green, blue} !== 12'h000) begin failures++; $display("FAIL reset_rgb got=%h exp=000", {red, green, blue}); end
    checks++; if (h_sync_out !== 1'b1) begin failures++; $display("FAIL reset_hsync got=%b exp=1", h_sync_out); end
    checks++; if (v_sync_out !== 1'b1) begin failures++; $display("FAIL reset_vsync got=%b exp=1", v_sync_out); end
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
    checks++; if (pattern_cur !== 2'd0) begin failures++; $display("FAIL reset_pattern got=%0d exp=0", pattern_cur); end
    h_sync_in = 1'b1; v_sync_in = 1'b1; pattern_sel = 2'd0;
    @(negedge clk); rst_n = 1'b1;
    frames = 0;
  endtask

  task automatic test_bars();
    int          xs [12] = '{0, 40, 79, 80, 160, 240, 320, 400, 480, 559, 560, 639};
    logic [11:0] ex [12] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                             12'hF0F, 12'hF00, 12'h00F, 12'h00F, 12'h000, 12'h000};
    logic [11:0] rgb;
    for (int i = 0; i < 12; i++) begin
      px(xs[i], 10, rgb);
      checks++;
      if (rgb !== ex[i]) begin failures++; $display("FAIL bars x=%0d got=%h exp=%h", xs[i], rgb, ex[i]); end
    end
  endtask

  task automatic test_checker();
    int          xs [4] = '{31, 32, 32, 0};
    int          ys [4] = '{0, 0, 32, 32};
    logic [11:0] ex [4] = '{12'h000, 12'hFFF, 12'h000, 12'hFFF};
    logic [11:0] rgb;
    pattern_sel = 2'd1;
    tick();
    checks++; if (pattern_cur !== 2'd1) begin failures++; $display("FAIL checker_sel got=%0d exp=1", pattern_cur); end
    for (int i = 0; i < 4; i++) begin
      px(xs[i], ys[i], rgb);
      checks++;
      if (rgb !== ex[i]) begin failures++; $display("FAIL checker (%0d,%0d) got=%h exp=%h", xs[i], ys[i], rgb, ex[i]); end
    end
  endtask

  // Pattern 1 on line 10: x 624..639 is white, display_en drops at 640; syncs toggle near the end.
  task automatic test_alignment();
    logic [13:0] ex [24];
    logic [13:0] got;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        got = {red, green, blue, h_sync_out, v_sync_out};
        checks++;
        if (got !== ex[i-2]) begin failures++; $display("FAIL align x=%0d got=%h exp=%h", 624 + i - 2, got, ex[i-2]); end
      end
      if (i < 24) begin
        set_px(624 + i, 10);
        h_sync_in = !((624 + i >= 644) && (624 + i < 646));
        v_sync_in = !(624 + i >= 646);
        ex[i] = {((624 + i) < 640) ? 12'hFFF : 12'h000, h_sync_in, v_sync_in};
      end else begin
        set_px(700, 10);
        h_sync_in = 1'b1; v_sync_in = 1'b1;
      end
    end
  endtask

  task automatic test_frame_tick();
    @(negedge clk); set_px(0, 480);
    @(negedge clk); set_px(700, 10);
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL tick_early got=%b exp=0", frame_tick); end
    @(negedge clk);
    frames++;
    checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL tick_high got=%b exp=1", frame_tick); end
    @(negedge clk);
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL tick_width got=%b exp=0", frame_tick); end
    @(negedge clk); set_px(0, 479);
    @(negedge clk); set_px(1, 480);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); set_px(700, 10);
      checks++;
      if (frame_tick !== 1'b0) begin failures++; $display("FAIL tick_false idx=%0d got=%b exp=0", i, frame_tick); end
    end
  endtask

  task automatic test_gradient();
    logic [11:0] rgb;
    logic [11:0] ex;
    pattern_sel = 2'd2;
    tick();
    px(90, 55, rgb);
    ex = {4'h5, 4'h3, 4'(frames)};
    checks++; if (rgb !== ex) begin failures++; $display("FAIL grad_a got=%h exp=%h", rgb, ex); end
    px(240, 192, rgb);
    ex = {4'hF, 4'hC, 4'(frames)};
    checks++; if (rgb !== ex) begin failures++; $display("FAIL grad_b got=%h exp=%h", rgb, ex); end
    repeat (14) tick();
    px(90, 55, rgb);
    ex = {4'h5, 4'h3, 4'(frames)};
    checks++; if (rgb !== ex) begin failures++; $display("FAIL grad_wrap got=%h exp=%h", rgb, ex); end
  endtask

  task automatic test_auto_cycle();
    logic [1:0] ex [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    apply_reset();
    pattern_sel = 2'd0; auto_cycle = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (pattern_cur !== ex[i]) begin failures++; $display("FAIL auto tick=%0d got=%0d exp=%0d", i + 1, pattern_cur, ex[i]); end
    end
    pattern_sel = 2'd2; auto_cycle = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pattern_cur !== 2'd0) begin failures++; $display("FAIL auto_off_hold got=%0d exp=0", pattern_cur); end
    tick();
    checks++; if (pattern_cur !== 2'd2) begin failures++; $display("FAIL auto_off_load got=%0d exp=2", pattern_cur); end
    pattern_sel = 2'd1;
    repeat (3) @(negedge clk);
    checks++; if (pattern_cur !== 2'd2) begin failures++; $display("FAIL sel_midframe got=%0d exp=2", pattern_cur); end
    auto_cycle = 1'b1;
    repeat (2) tick();
    checks++; if (pattern_cur !== 2'd2) begin failures++; $display("FAIL auto_restart_hold got=%0d exp=2", pattern_cur); end
    tick();
    checks++; if (pattern_cur !== 2'd3) begin failures++; $display("FAIL auto_restart_step got=%0d exp=3", pattern_cur); end
    auto_cycle = 1'b0;
  endtask

  task automatic test_box_bounce();
    int          stops [3] = '{448, 608, 609};
    int          bxs   [3] = '{448, 608, 607};
    int          bys   [3] = '{448, 288, 287};
    logic [11:0] pe    [4] = '{12'hFFF, 12'h008, 12'h008, 12'hFFF};
    int          ph [4];
    int          pv [4];
    int          n = 0;
    logic [11:0] rgb;
    apply_reset();
    auto_cycle = 1'b0; pattern_sel = 2'd3;
    for (int s = 0; s < 3; s++) begin
      while (n < stops[s]) begin tick(); n++; end
      ph = '{bxs[s], bxs[s] - 1, bxs[s], bxs[s] + 31};
      pv = '{bys[s], bys[s], bys[s] - 1, bys[s] + 31};
      for (int p = 0; p < 4; p++) begin
        px(ph[p], pv[p], rgb);
        checks++;
        if (rgb !== pe[p]) begin failures++; $display("FAIL box frame=%0d (%0d,%0d) got=%h exp=%h", n, ph[p], pv[p], rgb, pe[p]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int          ph [4] = '{1, 0, 1, 32};
    int          pv [4] = '{1, 1, 0, 32};
    logic [11:0] pe [4] = '{12'hFFF, 12'h008, 12'h008, 12'hFFF};
    logic [11:0] rgb;
    apply_reset();
    pattern_sel = 2'd3;
    repeat (5) tick();
    h_sync_in = 1'b0; v_sync_in = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); set_px(100 + i, 200); end
    @(negedge clk);
    checks++; if ({h_sync_out, v_sync_out} !== 2'b00) begin failures++; $display("FAIL mid_sync_pre got=%b exp=00", {h_sync_out, v_sync_out}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({red, green, blue} !== 12'h000) begin failures++; $display("FAIL mid_rgb got=%h exp=000", {red, green, blue}); end
    checks++; if ({h_sync_out, v_sync_out} !== 2'b11) begin failures++; $display("FAIL mid_sync got=%b exp=11", {h_sync_out, v_sync_out}); end
    checks++; if (pattern_cur !== 2'd0) begin failures++; $display("FAIL mid_pattern got=%0d exp=0", pattern_cur); end
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL mid_tick got=%b exp=0", frame_tick); end
    @(negedge clk);
    h_sync_in = 1'b1; v_sync_in = 1'b1; set_px(700, 10);
    @(negedge clk); rst_n = 1'b1;
    frames = 0;
    tick();
    for (int p = 0; p < 4; p++) begin
      px(ph[p], pv[p], rgb);
      checks++;
      if (rgb !== pe[p]) begin failures++; $display("FAIL mid_box (%0d,%0d) got=%h exp=%h", ph[p], pv[p], rgb, pe[p]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    h_sync_in = 1'b1; v_sync_in = 1'b1;
    pattern_sel = 2'd0; auto_cycle = 1'b0;
    set_px(700, 10);
    test_reset();
    test_bars();
    test_checker();
    test_alignment();
    test_frame_tick();
    test_gradient();
    test_auto_cycle();
    test_box_bounce();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Pixel-colour stage that sits directly downstream of `hvsync_generator` in the 640x480 VGA path, clocked by the pixel clock from `pixel_clk_480p`. Consumes the raw sync, counter and display-enable signals and produces registered 4-bit RGB plus delayed syncs, so colour and sync reach the pins aligned. Provides four selectable test patterns, including an animated bouncing box and an auto-cycle mode for bring-up on the Schoko board.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `BOX_SIZE`, 32: bouncing-box edge length in pixels.
- `AUTO_FRAMES`, 120: frames per pattern in auto-cycle mode; must be at least 1.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: asynchronous, active-low reset.
- `h_count` in 10: horizontal counter from the sync generator.
- `v_count` in 10: vertical counter from the sync generator.
- `display_en` in 1: high in the visible area.
- `h_sync_in` in 1: horizontal sync from the sync generator.
- `v_sync_in` in 1: vertical sync from the sync generator.
- `pattern_sel` in 2: manual pattern select.
- `auto_cycle` in 1: 1 = rotate patterns automatically.
- `red` out 4, `green` out 4, `blue` out 4: pixel colour.
- `h_sync_out` out 1, `v_sync_out` out 1: syncs delayed to match the RGB outputs.
- `frame_tick` out 1: one-cycle pulse per frame.
- `pattern_cur` out 2: pattern currently displayed.

## Operation
Pipeline, two register stages:
- **S1** registers `h_count`, `v_count`, `display_en` and both syncs. It also detects the frame start: `h_count==0 && v_count==V_ACTIVE`, the first blanking line.
- **S2** computes colour from the S1 values and registers RGB and the syncs.
- When S1 `display_en` is 0, RGB is 0.

Patterns, selected by `pattern_cur`:
- **0, colour bars.** Eight bars, each `H_ACTIVE/8` px wide. Order from x=0: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
- **1, checkerboard.** White when `h[5]^v[5]`, else black.
- **2, gradient.**
  - red = `h[7:4]`
  - green = `v[7:4]`
  - blue = `frame_cnt[3:0]`
- **3, bouncing box.**
  - Pixel is white when `bx <= h < bx+BOX_SIZE` and `by <= v < by+BOX_SIZE`.
  - Otherwise the pixel is the background: red 0, green 0, blue 8.

Frame update. When S1 detects the frame start it asserts `frame_tick`, registered, for one cycle. In that same cycle:
- `frame_cnt` (8-bit, wrapping) increments.
- Box x-position update, where `XMAX = H_ACTIVE-BOX_SIZE`:
  - If `dx=+1` and `bx==XMAX`: `dx` becomes -1 and `bx` becomes `bx-1`.
  - If `dx=-1` and `bx==0`: `dx` becomes +1 and `bx` becomes 1.
  - Otherwise `bx` becomes `bx+dx`.
- The y-position updates the same way with `by`, `dy` and `YMAX = V_ACTIVE-BOX_SIZE`.
- Pattern update:
  - If `auto_cycle` is 0: `pattern_cur` loads `pattern_sel` and `cyc_cnt` clears to 0.
  - If `auto_cycle` is 1 and `cyc_cnt == AUTO_FRAMES-1`: `cyc_cnt` becomes 0 and `pattern_cur` increments, wrapping from 3 to 0.
  - If `auto_cycle` is 1 otherwise: `cyc_cnt` increments.
- `pattern_cur`, `bx`, `by`, `dx` and `dy` change only on `frame_tick`. Changes to `pattern_sel` mid-frame never tear the image.

Boundary cases:
- `auto_cycle` going 1 to 0 takes effect at the next tick, which loads `pattern_sel`.
- `auto_cycle` going 0 to 1 starts from `cyc_cnt = 0`.
- A reset mid-frame forces all state to its reset value immediately. Output resumes correctly on the next frame.

## Timing
- Latency: each input sample appears on RGB and on `h_sync_out`/`v_sync_out` exactly 2 clocks later. RGB and syncs are always mutually aligned.
- `frame_tick` rises 2 clocks after the input cycle with `h_count==0, v_count==V_ACTIVE`. It is high for exactly 1 clock.
- New `pattern_cur`, box and counter values take effect on the first S2 evaluation after the tick.
- Reset values:
  - RGB 0.
  - `h_sync_out` and `v_sync_out` 1, the inactive level. The S1 sync registers also reset to 1.
  - `frame_tick` 0, `pattern_cur` 0.
  - `bx` 0, `by` 0, `dx` +1, `dy` +1.
  - `frame_cnt` 0, `cyc_cnt` 0.
- There is no handshake. The block consumes one sample every clock.

## Test plan
- **Alignment.** Drive a counter sweep with a `display_en` edge at x=640 → RGB goes to 0 exactly 2 clocks later. Sync toggles appear on the outputs 2 clocks later.
- **Bars.** Pattern 0 on line 10 → x=0..79 gives FFF, x=80 gives FF0, x=560..639 gives 000.
- **Checkerboard.** Pattern 1 → (31,0) gives 000, (32,0) gives FFF, (32,32) gives 000.
- **Box bounce.** Pattern 3, run 609 frames → `bx` reaches 608 at frame 608 and 607 at frame 609. `by` reaches 448 at frame 448 and is 287 at frame 609.
- **Auto-cycle.** `AUTO_FRAMES=3`, `auto_cycle=1` → `pattern_cur` goes 0,1,2,3,0 every 3 ticks. Deasserting with `pattern_sel=2` gives 2 at the next tick.
- **Reset mid-frame.** Assert `reset`=0 at line 200 → all outputs go to their reset values asynchronously. After release, box restarts from (0,0).
